counter_prog: RTL and testbench
===============================

COUNTER_PROG -- requirements
Module: counter_prog

Interface
REQ-001 SHALL have parameter DW, default 16: counter width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port clr_i, input, 1: synchronous clear of count and state.
REQ-005 SHALL have port load_i, input, 1: load load_val_i into count.
REQ-006 SHALL have port load_val_i, input, DW: value used by load.
REQ-007 SHALL have port en_i, input, 1: step qualifier, one step per cycle when high.
REQ-008 SHALL have port dir_i, input, 1: step direction, 0 = up, 1 = down.
REQ-009 SHALL have port mode_i, input, 2: 0 = WRAP, 1 = SAT, 2 = ONESHOT, 3 = reserved (behaves as WRAP).
REQ-010 SHALL have port max_i, input, DW: terminal value; range is 0..max_i inclusive.
REQ-011 SHALL have port count_o, output, DW: registered count.
REQ-012 SHALL have port tc_o, output, 1: registered one-cycle pulse marking a terminal event.
REQ-013 SHALL have port sat_o, output, 1: registered level, high while SAT mode holds at a limit.
REQ-014 SHALL have port done_o, output, 1: registered level, high while the ONESHOT state machine is in DONE.

Function
REQ-015 SHALL apply priority per cycle: rst > clr_i > load_i > en_i step > hold.
REQ-016 SHALL make clr_i act regardless of en_i: count_o <= 0, state <= IDLE, tc_o/sat_o/done_o <= 0.
REQ-017 SHALL on load_i set count_o <= min(load_val_i, max_i), state <= IDLE, tc_o <= 0; sat_o/done_o <= 0 next cycle.
REQ-018 SHALL define the terminal condition as: up and count_o >= max_i, or down and count_o == 0.
REQ-019 SHALL on an up step below max_i do count_o <= count_o + 1; on a down step above 0 do count_o <= count_o - 1; tc_o <= 0.
REQ-020 SHALL in WRAP on a terminal step load 0 (up) or max_i (down) and assert tc_o for exactly the next cycle.
REQ-021 SHALL in SAT on a terminal step hold count_o, clamped to max_i if above; sat_o <= 1; tc_o pulses only on the first step that reaches the limit, not on repeat holds.
REQ-022 SHALL in SAT clear sat_o on any non-terminal step, on a direction reversal step, and on clr_i/load_i.
REQ-023 SHALL in ONESHOT run the FSM IDLE -> RUN on the first en_i, and step on that same cycle.
REQ-024 SHALL in ONESHOT go RUN -> DONE on a terminal step: count holds at the limit, tc_o pulses once, and done_o <= 1.
REQ-025 SHALL in ONESHOT ignore en_i while in DONE, and leave DONE only via clr_i or load_i (-> IDLE).
REQ-026 SHALL apply a mode_i change immediately and keep count_o; the FSM returns to IDLE whenever mode_i != ONESHOT.
REQ-027 SHALL handle max_i == 0: every step is terminal; WRAP pulses tc_o every enabled cycle with count_o = 0.
REQ-028 SHALL hold all outputs when en_i = 0 and no clr_i/load_i, with tc_o <= 0.
REQ-029 SHALL perform all arithmetic in DW bits, with no carry out beyond the wrap/clamp rules above.

Reset
REQ-030 SHALL on rst set count_o = 0, tc_o = 0, sat_o = 0, done_o = 0, FSM = IDLE, effective the cycle after the edge with rst high.
REQ-031 SHALL let reset mid-run abandon any count or DONE state with no residual tc_o pulse.

Structure
REQ-032 SHALL place the mode encoding enum (WRAP/SAT/ONESHOT/RSVD) and the FSM state enum (IDLE/RUN/DONE) in a shared package counter_pkg.
REQ-033 SHALL be a single module with no sub-module; the next-value logic is one combinational block feeding one registered block.

Verification (DW = 4)
REQ-034 SHALL cover: WRAP, max_i = 9, up, en_i high 12 cycles from 0 -> count 0..9,0,1; tc_o high exactly the cycle count_o returns to 0.
REQ-035 SHALL cover: WRAP, down, max_i = 5, start 0 -> next count 5, tc_o pulse; then 4,3 with no pulse.
REQ-036 SHALL cover: SAT, max_i = 3, up 6 cycles -> 1,2,3,3,3,3; one tc_o pulse; sat_o high from the 3rd cycle; one dir_i = 1 step -> 2, sat_o low.
REQ-037 SHALL cover: ONESHOT, max_i = 4, en_i high 8 cycles -> 1..4 then hold at 4; done_o = 1; one tc_o pulse; a load_i of 2 -> count 2, done_o = 0, FSM IDLE.
REQ-038 SHALL cover: simultaneous clr_i, load_i(7) and en_i -> count 0; then load_i(12) with max_i = 9 -> count 9.
REQ-039 SHALL cover: rst asserted in ONESHOT DONE and in WRAP at a terminal step -> next cycle all outputs 0, no tc_o pulse.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings for the programmable counter: the counting-mode selector
// and the one-shot state machine states.
package counter_pkg;

  // Counting behaviour selected by mode_i; the reserved code acts as WRAP.
  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  // One-shot sequencing: wait for the first enable, count, then park in DONE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/counter_prog.sv
// Programmable up/down counter with wrap, saturate and one-shot modes over
// the range 0..max_i. All outputs are registered; one combinational block
// computes the next state and one registered block holds it.
module counter_prog
  import counter_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [DW-1:0] load_val_i,
  input  logic          en_i,
  input  logic          dir_i,
  input  logic [1:0]    mode_i,
  input  logic [DW-1:0] max_i,
  output logic [DW-1:0] count_o,
  output logic          tc_o,
  output logic          sat_o,
  output logic          done_o
);

  logic [DW-1:0] count_q, count_d;
  logic          tc_q, tc_d;
  logic          sat_q, sat_d;
  logic          satDir_q, satDir_d;
  state_e        state_q, state_d;

  logic [DW-1:0] stepVal;
  logic [DW-1:0] clampVal;
  logic [DW-1:0] loadClamp;
  logic          atTerm;
  logic          reachLimit;
  mode_e         modeSel;

  assign modeSel = mode_e'(mode_i);

  // Helper values: the plain step result, the limit-clamped current and load
  // values, whether this step starts at a terminal point, and whether a
  // non-terminal step lands exactly on the limit in its direction.
  always_comb begin
    stepVal    = dir_i ? (count_q - DW'(1)) : (count_q + DW'(1));
    clampVal   = (count_q > max_i) ? max_i : count_q;
    loadClamp  = (load_val_i > max_i) ? max_i : load_val_i;
    atTerm     = dir_i ? (count_q == '0) : (count_q >= max_i);
    reachLimit = dir_i ? (stepVal == '0) : (stepVal == max_i);
  end

  // Next-state logic with priority clr > load > enabled step > hold. The FSM
  // only lives in ONESHOT and the saturation flag only in SAT, so leaving
  // either mode drops them straight away. satDir remembers which limit the
  // saturation was reached at, so a reversal can be recognised even when
  // max_i is zero and both directions are terminal.
  always_comb begin
    count_d  = count_q;
    tc_d     = 1'b0;
    sat_d    = sat_q;
    satDir_d = satDir_q;
    state_d  = state_q;

    if (modeSel != MODE_ONESHOT) state_d = ST_IDLE;
    if (modeSel != MODE_SAT)     sat_d   = 1'b0;

    if (clr_i) begin
      count_d = '0;
      sat_d   = 1'b0;
      state_d = ST_IDLE;
    end else if (load_i) begin
      count_d = loadClamp;
      sat_d   = 1'b0;
      state_d = ST_IDLE;
    end else if (en_i) begin
      case (modeSel)
        MODE_SAT: begin
          if (atTerm) begin
            count_d = clampVal;
            if (sat_q && (dir_i != satDir_q)) begin
              sat_d = 1'b0;
            end else begin
              sat_d    = 1'b1;
              tc_d     = ~sat_q;
              satDir_d = dir_i;
            end
          end else begin
            count_d  = stepVal;
            sat_d    = reachLimit;
            tc_d     = reachLimit;
            satDir_d = dir_i;
          end
        end
        MODE_ONESHOT: begin
          if (state_q != ST_DONE) begin
            if (atTerm) begin
              count_d = clampVal;
              tc_d    = 1'b1;
              state_d = ST_DONE;
            end else begin
              count_d = stepVal;
              state_d = ST_RUN;
            end
          end
        end
        default: begin
          if (atTerm) begin
            count_d = dir_i ? max_i : '0;
            tc_d    = 1'b1;
          end else begin
            count_d = stepVal;
          end
        end
      endcase
    end
  end

  // State register with synchronous reset that abandons any run or DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      tc_q     <= 1'b0;
      sat_q    <= 1'b0;
      satDir_q <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      count_q  <= count_d;
      tc_q     <= tc_d;
      sat_q    <= sat_d;
      satDir_q <= satDir_d;
      state_q  <= state_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign sat_o   = sat_q;
  assign done_o  = (state_q == ST_DONE);

endmodule

// File: tb/tb_counter_prog.sv
// Directed bench for counter_prog at DW = 4: a table of single-cycle vectors
// with hand-computed results, plus reset sequences for the mid-run cases.
module tb_counter_prog;

  localparam int DW = 4;

  logic          clk;
  logic          rst;
  logic          clr_i;
  logic          load_i;
  logic [DW-1:0] load_val_i;
  logic          en_i;
  logic          dir_i;
  logic [1:0]    mode_i;
  logic [DW-1:0] max_i;
  logic [DW-1:0] count_o;
  logic          tc_o;
  logic          sat_o;
  logic          done_o;

  int checks;
  int failures;

  typedef struct {
    string         name;
    logic          clr;
    logic          load;
    logic [DW-1:0] loadVal;
    logic          en;
    logic          dir;
    logic [1:0]    mode;
    logic [DW-1:0] maxVal;
    logic [DW-1:0] expCount;
    logic          expTc;
    logic          expSat;
    logic          expDone;
  } vec_t;

  vec_t vecs[$];

  counter_prog #(.DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .en_i       (en_i),
    .dir_i      (dir_i),
    .mode_i     (mode_i),
    .max_i      (max_i),
    .count_o    (count_o),
    .tc_o       (tc_o),
    .sat_o      (sat_o),
    .done_o     (done_o)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input string name, input logic c, input logic l,
                        input logic [DW-1:0] lv, input logic e, input logic d,
                        input logic [1:0] m, input logic [DW-1:0] mx,
                        input logic [DW-1:0] ec, input logic et,
                        input logic es, input logic ed);
    vec_t v;
    v.name = name; v.clr = c; v.load = l; v.loadVal = lv; v.en = e;
    v.dir = d; v.mode = m; v.maxVal = mx; v.expCount = ec; v.expTc = et;
    v.expSat = es; v.expDone = ed;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then move to 1 time unit past the edge.
  task automatic applyStimulus(input logic r, input logic c, input logic l,
                               input logic [DW-1:0] lv, input logic e,
                               input logic d, input logic [1:0] m,
                               input logic [DW-1:0] mx);
    rst = r; clr_i = c; load_i = l; load_val_i = lv; en_i = e;
    dir_i = d; mode_i = m; max_i = mx;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOne(input string name, input string what,
                          input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s %s: got %0d expected %0d", name, what, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] ec,
                             input logic et, input logic es, input logic ed);
    checkOne(name, "count_o", int'(count_o), int'(ec));
    checkOne(name, "tc_o",    int'(tc_o),    int'(et));
    checkOne(name, "sat_o",   int'(sat_o),   int'(es));
    checkOne(name, "done_o",  int'(done_o),  int'(ed));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // WRAP up, max 9: 1..9, wrap to 0 with tc, then 1.
    for (int i = 1; i <= 9; i++)
      addVec("wrapUp", 0, 0, 0, 1, 0, 2'd0, 9, 4'(i), 0, 0, 0);
    addVec("wrapUpTc",   0, 0, 0, 1, 0, 2'd0, 9, 0, 1, 0, 0);
    addVec("wrapUpNext", 0, 0, 0, 1, 0, 2'd0, 9, 1, 0, 0, 0);
    // WRAP down, max 5 from 0: 5 with tc, then 4, 3, then hold.
    addVec("clrA",       1, 0, 0, 0, 1, 2'd0, 5, 0, 0, 0, 0);
    addVec("wrapDnTc",   0, 0, 0, 1, 1, 2'd0, 5, 5, 1, 0, 0);
    addVec("wrapDn4",    0, 0, 0, 1, 1, 2'd0, 5, 4, 0, 0, 0);
    addVec("wrapDn3",    0, 0, 0, 1, 1, 2'd0, 5, 3, 0, 0, 0);
    addVec("hold",       0, 0, 0, 0, 1, 2'd0, 5, 3, 0, 0, 0);
    // SAT up, max 3: 1,2,3(tc,sat),3,3,3; then one down step to 2.
    addVec("clrB",       1, 0, 0, 0, 0, 2'd1, 3, 0, 0, 0, 0);
    addVec("sat1",       0, 0, 0, 1, 0, 2'd1, 3, 1, 0, 0, 0);
    addVec("sat2",       0, 0, 0, 1, 0, 2'd1, 3, 2, 0, 0, 0);
    addVec("sat3Tc",     0, 0, 0, 1, 0, 2'd1, 3, 3, 1, 1, 0);
    addVec("satHold4",   0, 0, 0, 1, 0, 2'd1, 3, 3, 0, 1, 0);
    addVec("satHold5",   0, 0, 0, 1, 0, 2'd1, 3, 3, 0, 1, 0);
    addVec("satHold6",   0, 0, 0, 1, 0, 2'd1, 3, 3, 0, 1, 0);
    addVec("satRev",     0, 0, 0, 1, 1, 2'd1, 3, 2, 0, 0, 0);
    // ONESHOT, max 4: 1..4, DONE with tc, hold; load 2 leaves DONE.
    addVec("clrC",       1, 0, 0, 0, 0, 2'd2, 4, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      addVec("osRun",    0, 0, 0, 1, 0, 2'd2, 4, 4'(i), 0, 0, 0);
    addVec("osDoneTc",   0, 0, 0, 1, 0, 2'd2, 4, 4, 1, 0, 1);
    for (int i = 0; i < 3; i++)
      addVec("osDoneHold", 0, 0, 0, 1, 0, 2'd2, 4, 4, 0, 0, 1);
    addVec("osLoad2",    0, 1, 2, 1, 0, 2'd2, 4, 2, 0, 0, 0);
    addVec("osRestart",  0, 0, 0, 1, 0, 2'd2, 4, 3, 0, 0, 0);
    // Priority and load clamping.
    addVec("clrLoadEn",  1, 1, 7, 1, 0, 2'd0, 9, 0, 0, 0, 0);
    addVec("loadClamp",  0, 1, 12, 0, 0, 2'd0, 9, 9, 0, 0, 0);
    // Reserved mode behaves as WRAP at the terminal value.
    addVec("rsvdWrap",   0, 0, 0, 1, 0, 2'd3, 9, 0, 1, 0, 0);
    // max_i = 0: every enabled WRAP step is terminal.
    addVec("max0a",      0, 0, 0, 1, 0, 2'd0, 0, 0, 1, 0, 0);
    addVec("max0b",      0, 0, 0, 1, 0, 2'd0, 0, 0, 1, 0, 0);
    addVec("max0Idle",   0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);

    // Reset state.
    applyStimulus(1, 0, 0, 0, 0, 0, 2'd0, 9);
    applyStimulus(1, 0, 0, 0, 0, 0, 2'd0, 9);
    checkOutput("reset", 0, 0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].clr, vecs[i].load, vecs[i].loadVal, vecs[i].en,
                    vecs[i].dir, vecs[i].mode, vecs[i].maxVal);
      checkOutput(vecs[i].name, vecs[i].expCount, vecs[i].expTc,
                  vecs[i].expSat, vecs[i].expDone);
    end

    // Reset while parked in ONESHOT DONE.
    applyStimulus(0, 1, 0, 0, 0, 0, 2'd2, 2);
    applyStimulus(0, 0, 0, 0, 1, 0, 2'd2, 2);
    applyStimulus(0, 0, 0, 0, 1, 0, 2'd2, 2);
    checkOutput("osPreDone", 2, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 2'd2, 2);
    checkOutput("osDone2", 2, 1, 0, 1);
    applyStimulus(1, 0, 0, 0, 1, 0, 2'd2, 2);
    checkOutput("rstInDone", 0, 0, 0, 0);

    // Reset on what would be a WRAP terminal step; no tc afterwards.
    applyStimulus(0, 0, 1, 9, 0, 0, 2'd0, 9);
    checkOutput("preTermLoad", 9, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 2'd0, 9);
    checkOutput("rstAtTerm", 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 2'd0, 9);
    checkOutput("postRstIdle", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
